// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - op codes, default Q-format constants and saturation helper
package fxp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  localparam int FXP_DATA_WIDTH = 16;
  localparam int FXP_FIXED_PNT  = 8;

  localparam logic [FXP_DATA_WIDTH-1:0] FXP_ONE = FXP_DATA_WIDTH'(1) << FXP_FIXED_PNT;
  localparam logic [FXP_DATA_WIDTH-1:0] FXP_MAX = {1'b0, {(FXP_DATA_WIDTH-1){1'b1}}};
  localparam logic [FXP_DATA_WIDTH-1:0] FXP_MIN = {1'b1, {(FXP_DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic ovf;
    logic unf;
  } sat_t;

  // Range check of a 64-bit exact value against a width-bit signed format.
  function automatic sat_t saturate(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t s;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (width - 1));
    s.ovf = (v > hi);
    s.unf = (v < lo);
    return s;
  endfunction

endpackage

// File: rtl/fxp_div_iter.sv
// rtl/fxp_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
module fxp_div_iter #(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           dividend,
  input  logic [DATA_WIDTH-1:0]           divisor,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH+FIXED_PNT-1:0] quotient
);

  localparam int N  = DATA_WIDTH + FIXED_PNT;
  localparam int CW = $clog2(N);

  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dsr;
  logic [N-1:0]          q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] diff;
  logic                  ge;

  // q starts as the scaled dividend; its MSB feeds the remainder while quotient
  // bits shift in at the bottom. done marks the final step, so quotient here is
  // the finished value on that cycle.
  always_comb begin
    trial    = {rem, q[N-1]};
    ge       = (trial >= {1'b0, dsr});
    diff     = trial[DATA_WIDTH-1:0] - dsr;
    quotient = {q[N-2:0], ge};
    done     = busy && (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dsr  <= '0;
      q    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      dsr  <= divisor;
      q    <= {dividend, {FIXED_PNT{1'b0}}};
    end else if (busy) begin
      rem <= ge ? diff : trial[DATA_WIDTH-1:0];
      q   <= quotient;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fxp_arith_unit.sv
// rtl/fxp_arith_unit.sv - saturating signed fixed-point add/sub/mul/div unit
module fxp_arith_unit
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_DATA_WIDTH,
  parameter int FIXED_PNT  = FXP_FIXED_PNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  busy,
  output logic                  done
);

  localparam int N = DATA_WIDTH + FIXED_PNT;
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  accept;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic                  div_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [N-1:0]          quo;
  logic signed [63:0]    a_w;
  logic signed [63:0]    b_w;
  logic signed [63:0]    q_w;
  logic signed [63:0]    wide;
  sat_t                  sat;
  logic [DATA_WIDTH-1:0] result_n;

  assign accept    = start && !div_busy;
  assign div_start = accept && (op_e'(op) == OP_DIV) && (b != '0);
  assign a_mag     = a[DATA_WIDTH-1] ? -a : a;
  assign b_mag     = b[DATA_WIDTH-1] ? -b : b;
  assign busy      = div_busy;

  fxp_div_iter #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIXED_PNT (FIXED_PNT)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(a_mag),
    .divisor (b_mag),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(quo)
  );

  // Exact result in 64 bits; a finishing divide takes priority over the
  // single-cycle path, which cannot be accepted while the divider is busy.
  always_comb begin
    a_w  = 64'(signed'(a));
    b_w  = 64'(signed'(b));
    q_w  = {{(64-N){1'b0}}, quo};
    wide = '0;
    if (div_done) begin
      wide = div_neg ? -q_w : q_w;
    end else begin
      case (op_e'(op))
        OP_ADD: wide = a_w + b_w;
        OP_SUB: wide = a_w - b_w;
        OP_MUL: wide = (a_w * b_w) >>> FIXED_PNT;
        OP_DIV: wide = a[DATA_WIDTH-1] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
        default: wide = '0;
      endcase
    end
    sat      = saturate(wide, DATA_WIDTH);
    result_n = sat.ovf ? MAX_V : (sat.unf ? MIN_V : wide[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      done      <= 1'b0;
      div_neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (div_done || (accept && !div_start)) begin
        result    <= result_n;
        overflow  <= sat.ovf;
        underflow <= sat.unf;
        done      <= 1'b1;
      end
      if (div_start) div_neg <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_fxp_arith_unit.sv
// tb/tb_fxp_arith_unit.sv - vector table, random model comparison and handshake/reset sequences
module tb_fxp_arith_unit;
  import fxp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  fxp_arith_unit #(.DATA_WIDTH(16), .FIXED_PNT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .overflow (overflow),
    .underflow(underflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          busy_n;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Exact arithmetic on real values of the Q8.8 operands, then clipping.
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    longint ea, eb, ex, q, mag;
    exp_t   e;
    ea = longint'($signed(x));
    eb = longint'($signed(y));
    ex = 0;
    case (o)
      2'b00: ex = ea + eb;
      2'b01: ex = ea - eb;
      2'b10: begin
        ex = ea * eb;
        q  = ex / 256;
        if (ex < 0 && q * 256 != ex) q = q - 1;
        ex = q;
      end
      default: begin
        if (eb == 0) ex = (ea >= 0) ? (longint'(1) << 40) : -(longint'(1) << 40);
        else begin
          mag = (((ea < 0) ? -ea : ea) * 256) / ((eb < 0) ? -eb : eb);
          ex  = ((ea < 0) != (eb < 0)) ? -mag : mag;
        end
      end
    endcase
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (ex > 32767) begin
      e.res = FXP_MAX;
      e.ovf = 1'b1;
    end else if (ex < -32768) begin
      e.res = FXP_MIN;
      e.unf = 1'b1;
    end else begin
      e.res = ex[15:0];
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start  = 1'b0;
    a      = 16'($urandom);
    b      = 16'($urandom);
    op     = 2'($urandom);
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[10];

  initial begin
    int   lat, busy_n, n_done, first_done;
    logic [15:0] first_res;
    exp_t e;

    vecs[0] = '{2'b00, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{2'b01, 16'h0100, 16'h0300, 16'hFE00, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{2'b00, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{2'b01, 16'h8100, 16'h0200, 16'h8000, 1'b0, 1'b1, 1, 0};
    vecs[4] = '{2'b10, 16'h0180, 16'hFE00, 16'hFD00, 1'b0, 1'b0, 1, 0};
    vecs[5] = '{2'b10, 16'h4000, 16'h0400, 16'h7FFF, 1'b1, 1'b0, 1, 0};
    vecs[6] = '{2'b10, 16'h0001, 16'hFF00, 16'hFFFF, 1'b0, 1'b0, 1, 0};
    vecs[7] = '{2'b11, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 24};
    vecs[8] = '{2'b11, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25, 24};
    vecs[9] = '{2'b11, 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1, 0};

    repeat (3) @(negedge clk);
    check("reset_result", 64'(result), 64'h0);
    check("reset_flags", 64'({overflow, underflow}), 64'h0);
    check("reset_busy_done", 64'({busy, done}), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n);
      check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 64'(underflow), 64'(vecs[i].unf));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].busy_n));
      check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'h0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  o;
      logic [15:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = 16'($urandom);
      if (o == 2'b11 && $urandom_range(0, 3) == 0) y = 16'($urandom_range(0, 3));
      e = model(o, x, y);
      run_op(o, x, y, lat, busy_n);
      check($sformatf("rnd%0d_op%0d_%h_%h_result", i, o, x, y), 64'(result), 64'(e.res));
      check($sformatf("rnd%0d_flags", i), 64'({overflow, underflow}), 64'({e.ovf, e.unf}));
      check($sformatf("rnd%0d_latency", i), 64'(lat), (o == 2'b11 && y != 0) ? 64'd25 : 64'd1);
    end

    // Start during a divide must be ignored: exactly one done, from the divide.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 16'h0300; b = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; first_done = 0; first_res = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
          first_res  = result;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_done_count", 64'(n_done), 64'd1);
    check("busy_start_done_cycle", 64'(first_done), 64'd25);
    check("busy_start_result", 64'(first_res), 64'h0180);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 16'h0300; b = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_div_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'h0);
    check("abort_flags", 64'({overflow, underflow}), 64'h0);
    check("abort_busy_done", 64'({busy, done}), 64'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(n_done), 64'h0);
    run_op(2'b00, 16'h0180, 16'h0240, lat, busy_n);
    check("post_reset_add", 64'(result), 64'h03C0);
    check("post_reset_latency", 64'(lat), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
